// File: rtl/exe_pkg.sv
// rtl/exe_pkg.sv - shared types and field positions for the multi-cycle execute stage
package exe_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_OR   = 3'd1,
        ALU_MUL  = 3'd2,
        ALU_PASS = 3'd3,
        ALU_SUB  = 3'd4,
        ALU_AND  = 3'd5,
        ALU_XOR  = 3'd6,
        ALU_SLT  = 3'd7
    } alu_op_e;

    localparam int CTRL_MEM_MSB = 5;
    localparam int CTRL_MEM_LSB = 3;
    localparam int CTRL_ALU_MSB = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FWD_REG    = 2'd0,
        FWD_MEM    = 2'd1,
        FWD_WB     = 2'd2,
        FWD_WB_DEC = 2'd3
    } fwd_sel_e;

endpackage

// File: rtl/exe_mul_unit.sv
// rtl/exe_mul_unit.sv - operand latch plus pipelined multiplier with a done pulse
module exe_mul_unit
    import exe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] product_o,
    output logic              done_o
);

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              v_op_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            v_op_q <= 1'b0;
        end else begin
            v_op_q <= start_i;
            if (start_i) begin
                a_q <= a_i;
                b_q <= b_i;
            end
        end
    end

    // Each stage holds its value once the token passes, so the final product
    // stays stable while the parent waits for the output register to free up.
    if (MUL_LAT > 2) begin : g_pipe
        localparam int NSTG = MUL_LAT - 2;
        logic [DATA_W-1:0] prod_q [NSTG];
        logic [NSTG-1:0]   v_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < NSTG; i++) begin
                    prod_q[i] <= '0;
                end
                v_q <= '0;
            end else begin
                v_q[0] <= v_op_q;
                if (v_op_q) begin
                    prod_q[0] <= a_q * b_q;
                end
                for (int i = 1; i < NSTG; i++) begin
                    v_q[i] <= v_q[i-1];
                    if (v_q[i-1]) begin
                        prod_q[i] <= prod_q[i-1];
                    end
                end
            end
        end

        assign product_o = prod_q[NSTG-1];
        assign done_o    = v_q[NSTG-1];
    end else begin : g_comb
        assign product_o = a_q * b_q;
        assign done_o    = v_op_q;
    end

endmodule

// File: rtl/exe_stage_mc.sv
// rtl/exe_stage_mc.sv - execute stage with handshakes and multi-cycle multiply; EXE_OVF_FLAG_EN enables the overflow flag
module exe_stage_mc
    import exe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MUL_LAT    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dec_exe_valid,
    output logic                  exe_dec_ready,
    input  logic [5:0]            dec_exe_ctrl_sgs,
    input  logic [2*DATA_W-1:0]   dec_exe_reg_data,
    input  logic [DATA_W-1:0]     dec_exe_mem_wr_data,
    input  logic [REG_ADDR_W-1:0] dec_exe_reg_wr_add,
    input  logic [DATA_W-1:0]     mem_exe_reslt_data,
    input  logic [DATA_W-1:0]     wb_exe_reslt_data,
    input  logic [DATA_W-1:0]     wb_dec_exe_reslt_data,
    input  logic [1:0]            mux1_hctr,
    input  logic [1:0]            mux2_hctr,
    input  logic                  mem_exe_ready,
    output logic                  exe_mem_valid,
    output logic [DATA_W-1:0]     exe_mem_reslt_data_out,
    output logic [DATA_W-1:0]     exe_mem_wr_data,
    output logic [REG_ADDR_W-1:0] exe_mem_reg_wr_add,
    output logic [2:0]            exe_mem_ctrl_sgs,
    output logic                  exe_mem_ovf,
    output logic [DATA_W-1:0]     exe_dec_reslt_data,
    output logic [REG_ADDR_W-1:0] exe_hctrl_reg_wr_add_st,
    output logic                  exe_busy
);

    localparam bit MUL_MC = (MUL_LAT > 1);
    localparam int CNT_W  = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

    logic [DATA_W-1:0]     data1_reg, data2_reg, op1, op2, alu_res, mul_prod;
    alu_op_e               alu_op;
    logic                  is_mul_mc, accept, out_free, mul_done, ovf_c;
    logic                  load_alu, load_mul;

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  valid_q, ovf_q;
    logic [DATA_W-1:0]     res_q, wr_q, lat_wr_q;
    logic [REG_ADDR_W-1:0] addr_q, lat_addr_q;
    logic [2:0]            ctrl_q, lat_ctrl_q;

    assign data1_reg = dec_exe_reg_data[2*DATA_W-1:DATA_W];
    assign data2_reg = dec_exe_reg_data[DATA_W-1:0];
    assign alu_op    = alu_op_e'(dec_exe_ctrl_sgs[CTRL_ALU_MSB:0]);

    always_comb begin
        op1 = data1_reg;
        unique case (fwd_sel_e'(mux1_hctr))
            FWD_REG: op1 = data1_reg;
            FWD_MEM: op1 = mem_exe_reslt_data;
            FWD_WB:  op1 = wb_exe_reslt_data;
            default: op1 = wb_dec_exe_reslt_data;
        endcase
    end

    always_comb begin
        op2 = data2_reg;
        unique case (fwd_sel_e'(mux2_hctr))
            FWD_REG: op2 = data2_reg;
            FWD_MEM: op2 = mem_exe_reslt_data;
            FWD_WB:  op2 = wb_exe_reslt_data;
            default: op2 = wb_dec_exe_reslt_data;
        endcase
    end

    always_comb begin
        alu_res = '0;
        unique case (alu_op)
            ALU_ADD:  alu_res = op1 + op2;
            ALU_OR:   alu_res = op1 | op2;
            ALU_MUL:  alu_res = MUL_MC ? '0 : op1 * op2;
            ALU_PASS: alu_res = op2;
            ALU_SUB:  alu_res = op1 - op2;
            ALU_AND:  alu_res = op1 & op2;
            ALU_XOR:  alu_res = op1 ^ op2;
            default:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op1) < $signed(op2))};
        endcase
    end

`ifdef EXE_OVF_FLAG_EN
    always_comb begin
        ovf_c = 1'b0;
        if (alu_op == ALU_ADD) begin
            ovf_c = (op1[DATA_W-1] == op2[DATA_W-1]) && (alu_res[DATA_W-1] != op1[DATA_W-1]);
        end else if (alu_op == ALU_SUB) begin
            ovf_c = (op1[DATA_W-1] != op2[DATA_W-1]) && (alu_res[DATA_W-1] != op1[DATA_W-1]);
        end
    end
`else
    assign ovf_c = 1'b0;
`endif

    assign out_free  = !valid_q || mem_exe_ready;
    assign is_mul_mc = MUL_MC && (alu_op == ALU_MUL);
    assign accept    = dec_exe_valid && exe_dec_ready;
    assign load_alu  = accept && !is_mul_mc;
    assign load_mul  = out_free && ((state_q == BUSY && cnt_q == CNT_LAST && mul_done) ||
                                    (state_q == WAIT));

    exe_mul_unit #(
        .DATA_W  (DATA_W),
        .MUL_LAT (MUL_LAT)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (accept && is_mul_mc),
        .a_i       (op1),
        .b_i       (op2),
        .product_o (mul_prod),
        .done_o    (mul_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            res_q      <= '0;
            wr_q       <= '0;
            addr_q     <= '0;
            ctrl_q     <= '0;
            ovf_q      <= 1'b0;
            lat_wr_q   <= '0;
            lat_addr_q <= '0;
            lat_ctrl_q <= '0;
        end else begin
            // Drain and load can coincide; a load simply wins over the clear.
            if (load_alu) begin
                valid_q <= 1'b1;
                res_q   <= alu_res;
                wr_q    <= dec_exe_mem_wr_data;
                addr_q  <= dec_exe_reg_wr_add;
                ctrl_q  <= dec_exe_ctrl_sgs[CTRL_MEM_MSB:CTRL_MEM_LSB];
                ovf_q   <= ovf_c;
            end else if (load_mul) begin
                valid_q <= 1'b1;
                res_q   <= mul_prod;
                wr_q    <= lat_wr_q;
                addr_q  <= lat_addr_q;
                ctrl_q  <= lat_ctrl_q;
                ovf_q   <= 1'b0;
            end else if (valid_q && mem_exe_ready) begin
                valid_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (accept && is_mul_mc) begin
                        state_q    <= BUSY;
                        cnt_q      <= CNT_W'(1);
                        lat_wr_q   <= dec_exe_mem_wr_data;
                        lat_addr_q <= dec_exe_reg_wr_add;
                        lat_ctrl_q <= dec_exe_ctrl_sgs[CTRL_MEM_MSB:CTRL_MEM_LSB];
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST && mul_done) begin
                        if (out_free) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (out_free) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign exe_dec_ready           = (state_q == IDLE) && out_free;
    assign exe_busy                = (state_q != IDLE);
    assign exe_hctrl_reg_wr_add_st = (state_q == IDLE) ? dec_exe_reg_wr_add : lat_addr_q;
    assign exe_dec_reslt_data      = alu_res;
    assign exe_mem_valid           = valid_q;
    assign exe_mem_reslt_data_out  = res_q;
    assign exe_mem_wr_data         = wr_q;
    assign exe_mem_reg_wr_add      = addr_q;
    assign exe_mem_ctrl_sgs        = ctrl_q;
    assign exe_mem_ovf             = ovf_q;

endmodule

// File: tb/tb_exe_stage_mc.sv
// tb/tb_exe_stage_mc.sv - randomized bench for exe_stage_mc against a cycle-stamped reference model
module tb_exe_stage_mc;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int ML = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dec_valid;
    logic [5:0]    ctrl;
    logic [63:0]   reg_data;
    logic [31:0]   wr_data, mem_fwd, wb_fwd, wbd_fwd;
    logic [4:0]    waddr;
    logic [1:0]    m1, m2;
    logic          mem_ready;

    logic          dec_ready, o_valid, o_ovf, busy;
    logic [31:0]   o_res, o_wr, dec_res;
    logic [4:0]    o_addr, hctrl;
    logic [2:0]    o_ctrl;

    always #5 clk = ~clk;

    exe_stage_mc #(.DATA_W(DW), .REG_ADDR_W(AW), .MUL_LAT(ML)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .dec_exe_valid           (dec_valid),
        .exe_dec_ready           (dec_ready),
        .dec_exe_ctrl_sgs        (ctrl),
        .dec_exe_reg_data        (reg_data),
        .dec_exe_mem_wr_data     (wr_data),
        .dec_exe_reg_wr_add      (waddr),
        .mem_exe_reslt_data      (mem_fwd),
        .wb_exe_reslt_data       (wb_fwd),
        .wb_dec_exe_reslt_data   (wbd_fwd),
        .mux1_hctr               (m1),
        .mux2_hctr               (m2),
        .mem_exe_ready           (mem_ready),
        .exe_mem_valid           (o_valid),
        .exe_mem_reslt_data_out  (o_res),
        .exe_mem_wr_data         (o_wr),
        .exe_mem_reg_wr_add      (o_addr),
        .exe_mem_ctrl_sgs        (o_ctrl),
        .exe_mem_ovf             (o_ovf),
        .exe_dec_reslt_data      (dec_res),
        .exe_hctrl_reg_wr_add_st (hctrl),
        .exe_busy                (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference: expected output register plus at most one pending product
    // tagged with the edge number at which it becomes loadable.
    bit          m_valid, m_ovf, p_pend, last_stalled;
    logic [31:0] m_res, m_wr, p_res, p_wr;
    logic [4:0]  m_addr, p_addr;
    logic [2:0]  m_ctrl, p_ctrl;
    int          p_due, edge_n;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] r);
        case (sel)
            2'd0:    return r;
            2'd1:    return mem_fwd;
            2'd2:    return wb_fwd;
            default: return wbd_fwd;
        endcase
    endfunction

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a | b;
            3'd2:    return a * b;
            3'd3:    return b;
            3'd4:    return a - b;
            3'd5:    return a & b;
            3'd6:    return a ^ b;
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic bit ovf_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = (op == 3'd0) ? sa + sb : sa - sb;
`ifdef EXE_OVF_FLAG_EN
        return (op == 3'd0 || op == 3'd4) && (s > 64'sd2147483647 || s < -64'sd2147483648);
`else
        return (s == s) ? 1'b0 : 1'b0;
`endif
    endfunction

    task automatic check_comb();
        logic [31:0] a, b;
        logic [2:0]  op;
        a  = fwd(m1, reg_data[63:32]);
        b  = fwd(m2, reg_data[31:0]);
        op = ctrl[2:0];
        chk("ready", dec_ready, !p_pend && (!m_valid || mem_ready));
        chk("busy", busy, p_pend);
        chk("hctrl_addr", hctrl, p_pend ? p_addr : waddr);
        chk("dec_result", dec_res, (op == 3'd2) ? 32'd0 : alu_ref(op, a, b));
    endtask

    task automatic model_edge();
        bit          free, acc;
        logic [31:0] a, b;
        logic [2:0]  op;
        free = !m_valid || mem_ready;
        acc  = 1'b0;
        a    = fwd(m1, reg_data[63:32]);
        b    = fwd(m2, reg_data[31:0]);
        op   = ctrl[2:0];
        edge_n++;
        if (p_pend) begin
            if (edge_n >= p_due && free) begin
                m_valid = 1'b1; m_res = p_res; m_wr = p_wr;
                m_addr = p_addr; m_ctrl = p_ctrl; m_ovf = 1'b0;
                p_pend = 1'b0;
            end else if (m_valid && mem_ready) begin
                m_valid = 1'b0;
            end
        end else if (dec_valid && free) begin
            acc = 1'b1;
            if (op == 3'd2) begin
                p_pend = 1'b1; p_due = edge_n + ML - 1;
                p_res = a * b; p_wr = wr_data; p_addr = waddr; p_ctrl = ctrl[5:3];
                if (m_valid && mem_ready) m_valid = 1'b0;
            end else begin
                m_valid = 1'b1; m_res = alu_ref(op, a, b); m_wr = wr_data;
                m_addr = waddr; m_ctrl = ctrl[5:3]; m_ovf = ovf_ref(op, a, b);
            end
        end else if (m_valid && mem_ready) begin
            m_valid = 1'b0;
        end
        last_stalled = dec_valid && !acc;
    endtask

    task automatic check_regs();
        chk("out_valid", o_valid, m_valid);
        chk("out_result", o_res, m_res);
        chk("out_wr_data", o_wr, m_wr);
        chk("out_addr", o_addr, m_addr);
        chk("out_ctrl", o_ctrl, m_ctrl);
        chk("out_ovf", o_ovf, m_ovf);
    endtask

    task automatic step();
        #1 check_comb();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_regs();
    endtask

    task automatic model_reset();
        m_valid = 0; m_ovf = 0; m_res = '0; m_wr = '0; m_addr = '0; m_ctrl = '0;
        p_pend = 0; p_res = '0; p_wr = '0; p_addr = '0; p_ctrl = '0;
        last_stalled = 0;
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_result", o_res, 0);
        chk("rst_wr", o_wr, 0);
        chk("rst_addr", o_addr, 0);
        chk("rst_ctrl", o_ctrl, 0);
        chk("rst_ovf", o_ovf, 0);
        chk("rst_busy", busy, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_op(input logic [2:0] op, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [1:0] s1, input logic [1:0] s2, input logic [4:0] ad);
        dec_valid = 1'b1;
        ctrl      = {3'($urandom_range(0, 7)), op};
        reg_data  = {d1, d2};
        wr_data   = $urandom;
        waddr     = ad;
        m1        = s1;
        m2        = s2;
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] edges [4];
        edges[0] = 32'h7FFF_FFFF; edges[1] = 32'h8000_0000;
        edges[2] = 32'hFFFF_FFFF; edges[3] = 32'h0000_0001;
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 15));
            1:       return edges[$urandom_range(0, 3)];
            default: return $urandom;
        endcase
    endfunction

    initial begin
        dec_valid = 0; ctrl = '0; reg_data = '0; wr_data = '0; waddr = '0;
        mem_fwd = '0; wb_fwd = '0; wbd_fwd = '0; m1 = '0; m2 = '0; mem_ready = 0;
        edge_n = 0; p_due = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("init_valid", o_valid, 0);
        chk("init_result", o_res, 0);
        chk("init_ready", dec_ready, 1);
        chk("init_busy", busy, 0);
        @(negedge clk);

        mem_ready = 1'b1;
        set_op(3'd0, 32'd5, 32'd7, 2'd0, 2'd0, 5'd3);
        step();
        chk("add_lit", o_res, 32'd12);
        chk("add_valid_lit", o_valid, 1);
        set_op(3'd1, 32'hF0, 32'h0F, 2'd0, 2'd0, 5'd4);
        step();
        chk("or_lit", o_res, 32'hFF);

        set_op(3'd2, 32'd6, 32'd7, 2'd0, 2'd0, 5'd7);
        step();
        dec_valid = 1'b0; waddr = 5'd9;
        #1 chk("mul_ready_lit", dec_ready, 0);
        chk("mul_busy_lit", busy, 1);
        chk("mul_hctrl_lit", hctrl, 5'd7);
        step();
        chk("mul_busy2_lit", busy, 1);
        step();
        chk("mul_lit", o_res, 32'd42);
        chk("mul_valid_lit", o_valid, 1);
        chk("mul_idle_lit", busy, 0);

        set_op(3'd2, 32'd6, 32'd7, 2'd0, 2'd0, 5'd4);
        step();
        dec_valid = 1'b0; mem_ready = 1'b0;
        step();
        step();
        chk("mul_nordy_lit", o_res, 32'd42);
        set_op(3'd0, 32'd1, 32'd1, 2'd0, 2'd0, 5'd1);
        step();
        chk("hold_lit", o_res, 32'd42);
        mem_ready = 1'b1;
        step();
        chk("drain_load_lit", o_res, 32'd2);

        wb_fwd = 32'd100; mem_fwd = 32'd1;
        set_op(3'd4, 32'hDEAD, 32'hBEEF, 2'd2, 2'd1, 5'd5);
        step();
        chk("fwd_sub_lit", o_res, 32'd99);
        set_op(3'd7, 32'hFFFF_FFFF, 32'd1, 2'd0, 2'd0, 5'd6);
        step();
        chk("slt_lit", o_res, 32'd1);
        set_op(3'd0, 32'h7FFF_FFFF, 32'd1, 2'd0, 2'd0, 5'd8);
        step();
        chk("ovf_res_lit", o_res, 32'h8000_0000);
`ifdef EXE_OVF_FLAG_EN
        chk("ovf_flag_lit", o_ovf, 1);
`else
        chk("ovf_flag_lit", o_ovf, 0);
`endif

        set_op(3'd2, 32'd6, 32'd7, 2'd0, 2'd0, 5'd10);
        step();
        dec_valid = 1'b0;
        apply_reset();
        #1 chk("post_rst_ready", dec_ready, 1);
        for (int i = 0; i < 5; i++) step();
        chk("no_stale_valid", o_valid, 0);
        chk("no_stale_result", o_res, 0);

        for (int c = 0; c < 3000; c++) begin
            if (!last_stalled) begin
                dec_valid = ($urandom_range(0, 9) < 7);
                ctrl      = 6'($urandom);
                reg_data  = {rnd_word(), rnd_word()};
                wr_data   = $urandom;
                waddr     = 5'($urandom);
                m1        = 2'($urandom);
                m2        = 2'($urandom);
            end
            mem_fwd   = rnd_word();
            wb_fwd    = rnd_word();
            wbd_fwd   = rnd_word();
            mem_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 699) == 0) apply_reset();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
